// File: rtl/calculator_keypad_ctrl_pkg.sv
// calc_pkg: constants shared by the keypad controller, calculator_screen
// and the ALU.
//   GRID_COLS/GRID_ROWS : on-screen key grid size (6x4)
//   OP_ADD..OP_OR       : operation codes carried on `op`
//   KEY_*               : key indices, k = pos_y*GRID_COLS + pos_x
//   calc_state_t        : entry-controller states
package calc_pkg;

    localparam int GRID_COLS = 6;
    localparam int GRID_ROWS = 4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;

    localparam logic [4:0] KEY_OP_FIRST = 5'd16;
    localparam logic [4:0] KEY_OP_LAST  = 5'd20;
    localparam logic [4:0] KEY_CE       = 5'd21;
    localparam logic [4:0] KEY_CLR      = 5'd22;
    localparam logic [4:0] KEY_EXE      = 5'd23;

    typedef enum logic [1:0] {
        ENTER_OP1   = 2'd0,
        ENTER_OP2   = 2'd1,
        SHOW_RESULT = 2'd2
    } calc_state_t;

endpackage

// File: rtl/calculator_keypad_ctrl_btn_edge_detect.sv
// btn_edge_detect: rising-edge detector for WIDTH debounced button levels.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_lvl      : button levels
//   o_rise     : one-cycle pulse per 0->1 transition (combinational from i_lvl)
module btn_edge_detect #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_lvl,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_prev;
    // Cleared by reset and set on the first clock afterwards. While clear,
    // edges are masked so that a button already held when reset releases
    // only loads r_prev and never acts.
    logic             r_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_lvl;
            r_armed <= 1'b1;
        end
    end

    assign o_rise = r_armed ? (i_lvl & ~r_prev) : '0;

endmodule

// File: rtl/calculator_keypad_ctrl.sv
// calculator_keypad_ctrl: cursor and operand-entry controller in front of
// calculator_screen.
//   clk, rst_n                      : clock, async active-low reset
//   btn_u/d/l/r/c                   : debounced button levels (edge-acted)
//   mode                            : 0 = decimal entry, 1 = hex entry
//   result                          : ALU result (combinational from op/op1/op2)
//   pos_x, pos_y                    : cursor column/row
//   op, op1, op2                    : selected operation and operands
//   input_screen                    : entry display value
//   exe                             : one-cycle execute strobe
module calculator_keypad_ctrl
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic        btn_c,
    input  logic        mode,
    input  logic [15:0] result,
    output logic [2:0]  pos_x,
    output logic [1:0]  pos_y,
    output logic [2:0]  op,
    output logic [15:0] op1,
    output logic [15:0] op2,
    output logic [15:0] input_screen,
    output logic        exe
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [4:0]    w_rise;  // {c, u, d, l, r}
    calc_state_t   r_state, w_state;
    logic [2:0]    r_pos_x, w_pos_x, r_op, w_op;
    logic [1:0]    r_pos_y, w_pos_y;
    logic [15:0]   r_op1, w_op1, r_op2, w_op2;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_exe, w_exe;
    logic [4:0]    w_key;
    logic          w_is_digit, w_is_op, w_room;

    btn_edge_detect #(.WIDTH(5)) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_lvl  ({btn_c, btn_u, btn_d, btn_l, btn_r}),
        .o_rise (w_rise)
    );

    assign w_key      = {3'b000, r_pos_y} * 5'd6 + {2'b00, r_pos_x};
    assign w_is_digit = (w_key < 5'd16) && (mode || w_key < 5'd10);
    assign w_is_op    = (w_key >= KEY_OP_FIRST) && (w_key <= KEY_OP_LAST);
    assign w_room     = r_cnt < CW'(MAX_DIGITS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ENTER_OP1;
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_op    <= OP_ADD;
            r_op1   <= '0;
            r_op2   <= '0;
            r_cnt   <= '0;
            r_exe   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pos_x <= w_pos_x;
            r_pos_y <= w_pos_y;
            r_op    <= w_op;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_cnt   <= w_cnt;
            r_exe   <= w_exe;
        end
    end

    // One action per cycle; the if/else chain encodes priority C > U > D > L > R.
    always_comb begin
        w_state = r_state;
        w_pos_x = r_pos_x;
        w_pos_y = r_pos_y;
        w_op    = r_op;
        w_op1   = r_op1;
        w_op2   = r_op2;
        w_cnt   = r_cnt;
        w_exe   = 1'b0;
        if (w_rise[4]) begin
            if (w_key == KEY_CLR || (r_state == SHOW_RESULT && w_key == KEY_CE)) begin
                w_state = ENTER_OP1;
                w_op    = OP_ADD;
                w_op1   = '0;
                w_op2   = '0;
                w_cnt   = '0;
            end else begin
                case (r_state)
                    ENTER_OP1: begin
                        if (w_is_digit) begin
                            if (w_room) begin
                                w_op1 = {r_op1[11:0], w_key[3:0]};
                                w_cnt = r_cnt + 1'b1;
                            end
                        end else if (w_is_op) begin
                            w_op    = 3'(w_key - KEY_OP_FIRST);
                            w_op2   = '0;
                            w_cnt   = '0;
                            w_state = ENTER_OP2;
                        end else if (w_key == KEY_CE) begin
                            w_op1 = '0;
                            w_cnt = '0;
                        end
                    end
                    ENTER_OP2: begin
                        if (w_is_digit) begin
                            if (w_room) begin
                                w_op2 = {r_op2[11:0], w_key[3:0]};
                                w_cnt = r_cnt + 1'b1;
                            end
                        end else if (w_is_op) begin
                            w_op = 3'(w_key - KEY_OP_FIRST);
                        end else if (w_key == KEY_CE) begin
                            w_op2 = '0;
                            w_cnt = '0;
                        end else if (w_key == KEY_EXE) begin
                            w_exe   = 1'b1;
                            w_state = SHOW_RESULT;
                        end
                    end
                    SHOW_RESULT: begin
                        if (w_is_digit) begin
                            w_op1   = {12'h000, w_key[3:0]};
                            w_op2   = '0;
                            w_cnt   = CW'(1);
                            w_state = ENTER_OP1;
                        end else if (w_is_op) begin
                            // Chaining: the previous result becomes the new left operand.
                            w_op1   = result;
                            w_op    = 3'(w_key - KEY_OP_FIRST);
                            w_op2   = '0;
                            w_cnt   = '0;
                            w_state = ENTER_OP2;
                        end else if (w_key == KEY_EXE) begin
                            w_exe = 1'b1;
                        end
                    end
                    default: w_state = ENTER_OP1;
                endcase
            end
        end else if (w_rise[3]) begin
            w_pos_y = (r_pos_y == 2'd0) ? 2'(GRID_ROWS - 1) : r_pos_y - 1'b1;
        end else if (w_rise[2]) begin
            w_pos_y = (r_pos_y == 2'(GRID_ROWS - 1)) ? 2'd0 : r_pos_y + 1'b1;
        end else if (w_rise[1]) begin
            w_pos_x = (r_pos_x == 3'd0) ? 3'(GRID_COLS - 1) : r_pos_x - 1'b1;
        end else if (w_rise[0]) begin
            w_pos_x = (r_pos_x == 3'(GRID_COLS - 1)) ? 3'd0 : r_pos_x + 1'b1;
        end
    end

    assign pos_x = r_pos_x;
    assign pos_y = r_pos_y;
    assign op    = r_op;
    assign op1   = r_op1;
    assign op2   = r_op2;
    assign exe   = r_exe;

    always_comb begin
        case (r_state)
            ENTER_OP2:   input_screen = r_op2;
            SHOW_RESULT: input_screen = result;
            default:     input_screen = r_op1;
        endcase
    end

endmodule

// File: tb/tb_calculator_keypad_ctrl.sv
module tb_calculator_keypad_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_u, btn_d, btn_l, btn_r, btn_c;
    logic        mode;
    logic [15:0] result;
    logic [2:0]  pos_x, op;
    logic [1:0]  pos_y;
    logic [15:0] op1, op2, input_screen;
    logic        exe;

    int errors = 0;
    int checks = 0;
    int exe_cnt = 0;

    // Reference model: states 0 = entering op1, 1 = entering op2, 2 = showing result
    int          m_st, m_px, m_py, m_op, m_cnt;
    logic [15:0] m_op1, m_op2;
    bit          m_exe;

    localparam logic [4:0] B_C = 5'b10000, B_U = 5'b01000, B_D = 5'b00100,
                           B_L = 5'b00010, B_R = 5'b00001;

    calculator_keypad_ctrl #(.MAX_DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r), .btn_c(btn_c),
        .mode(mode), .result(result),
        .pos_x(pos_x), .pos_y(pos_y), .op(op), .op1(op1), .op2(op2),
        .input_screen(input_screen), .exe(exe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (exe) exe_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] m_screen();
        return (m_st == 0) ? m_op1 : (m_st == 1) ? m_op2 : result;
    endfunction

    task automatic model_reset();
        m_st = 0; m_px = 0; m_py = 0; m_op = 0; m_cnt = 0;
        m_op1 = 0; m_op2 = 0; m_exe = 0;
    endtask

    task automatic model_clear();
        m_st = 0; m_op = 0; m_cnt = 0; m_op1 = 0; m_op2 = 0;
    endtask

    // Apply one button edge-set using the key-grid rules.
    task automatic model_apply(input logic [4:0] m);
        int k;
        int v;
        k = m_py * 6 + m_px;
        m_exe = 0;
        if (m[4]) begin
            if (k == 22 || (m_st == 2 && k == 21)) model_clear();
            else if (k < 16) begin
                if (mode || k < 10) begin
                    if (m_st == 2) begin
                        m_op1 = 16'(k); m_op2 = 0; m_cnt = 1; m_st = 0;
                    end else if (m_cnt < 4) begin
                        v = (m_st == 0) ? int'(m_op1) : int'(m_op2);
                        v = (v * 16 + k) % 65536;
                        if (m_st == 0) m_op1 = 16'(v); else m_op2 = 16'(v);
                        m_cnt++;
                    end
                end
            end else if (k <= 20) begin
                m_op = k - 16;
                if (m_st == 2) m_op1 = result;
                if (m_st != 1) begin m_op2 = 0; m_cnt = 0; end
                m_st = 1;
            end else if (k == 21) begin
                if (m_st == 0) m_op1 = 0; else m_op2 = 0;
                m_cnt = 0;
            end else begin
                if (m_st == 1) begin m_exe = 1; m_st = 2; end
                else if (m_st == 2) m_exe = 1;
            end
        end else if (m[3]) m_py = (m_py + 3) % 4;
        else if (m[2]) m_py = (m_py + 1) % 4;
        else if (m[1]) m_px = (m_px + 5) % 6;
        else if (m[0]) m_px = (m_px + 1) % 6;
    endtask

    task automatic do_press(input logic [4:0] m);
        @(negedge clk);
        {btn_c, btn_u, btn_d, btn_l, btn_r} = m;
        model_apply(m);
        @(negedge clk);
        {btn_c, btn_u, btn_d, btn_l, btn_r} = 5'b0;
        @(negedge clk);
    endtask

    task automatic goto_key(input int k);
        while (m_px != k % 6) do_press(B_R);
        while (m_py != k / 6) do_press(B_D);
    endtask

    task automatic press_key(input int k);
        goto_key(k);
        do_press(B_C);
    endtask

    task automatic apply_reset();
        {btn_c, btn_u, btn_d, btn_l, btn_r} = 5'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (pos_x !== 3'd0) begin errors++; $display("FAIL reset_pos_x got=%0d exp=0", pos_x); end
        checks++; if (pos_y !== 2'd0) begin errors++; $display("FAIL reset_pos_y got=%0d exp=0", pos_y); end
        checks++; if (op !== 3'd0) begin errors++; $display("FAIL reset_op got=%0d exp=0", op); end
        checks++; if (op1 !== 16'h0 || op2 !== 16'h0) begin errors++; $display("FAIL reset_ops got=%h/%h exp=0/0", op1, op2); end
        checks++; if (input_screen !== 16'h0 || exe !== 1'b0) begin errors++; $display("FAIL reset_screen_exe got=%h/%b exp=0/0", input_screen, exe); end
    endtask

    task automatic test_cursor_wrap();
        do_press(B_L);
        checks++; if (pos_x !== 3'd5 || pos_y !== 2'd0) begin errors++; $display("FAIL wrap_left got=(%0d,%0d) exp=(5,0)", pos_x, pos_y); end
        do_press(B_U);
        checks++; if (pos_x !== 3'd5 || pos_y !== 2'd3) begin errors++; $display("FAIL wrap_up got=(%0d,%0d) exp=(5,3)", pos_x, pos_y); end
        do_press(B_R);
        checks++; if (pos_x !== 3'd0 || pos_y !== 2'd3) begin errors++; $display("FAIL wrap_right got=(%0d,%0d) exp=(0,3)", pos_x, pos_y); end
        do_press(B_D);
        checks++; if (pos_y !== 2'd0) begin errors++; $display("FAIL wrap_down got=%0d exp=0", pos_y); end
    endtask

    task automatic test_hex_entry();
        int e0;
        mode = 1'b1;
        result = 16'h5A5A;
        press_key(1); press_key(2); press_key(10); press_key(11); press_key(12);
        checks++; if (op1 !== 16'h12AB) begin errors++; $display("FAIL hex_op1 got=%h exp=12ab", op1); end
        checks++; if (input_screen !== 16'h12AB) begin errors++; $display("FAIL hex_screen got=%h exp=12ab", input_screen); end
        press_key(16);
        press_key(3);
        checks++; if (op !== 3'd0 || op2 !== 16'h0003) begin errors++; $display("FAIL hex_op2 got=%0d/%h exp=0/0003", op, op2); end
        goto_key(23);
        e0 = exe_cnt;
        do_press(B_C);
        checks++; if (exe_cnt - e0 !== 1) begin errors++; $display("FAIL exe_pulse got=%0d cycles exp=1", exe_cnt - e0); end
        checks++; if (input_screen !== 16'h5A5A) begin errors++; $display("FAIL show_result got=%h exp=5a5a", input_screen); end
        result = 16'h1234;
        #1;
        checks++; if (input_screen !== 16'h1234) begin errors++; $display("FAIL result_comb got=%h exp=1234", input_screen); end
    endtask

    task automatic test_chaining();
        result = 16'h0042;
        press_key(18);
        checks++; if (op1 !== 16'h0042 || op !== 3'd2 || op2 !== 16'h0) begin
            errors++; $display("FAIL chain got=op1 %h op %0d op2 %h exp=0042 2 0000", op1, op, op2); end
        checks++; if (input_screen !== 16'h0000) begin errors++; $display("FAIL chain_state got=%h exp=0000", input_screen); end
    endtask

    task automatic test_decimal();
        press_key(22);
        checks++; if (op1 !== 16'h0 || op !== 3'd0) begin errors++; $display("FAIL clr got=%h/%0d exp=0/0", op1, op); end
        mode = 1'b0;
        press_key(10);
        checks++; if (op1 !== 16'h0) begin errors++; $display("FAIL dec_gate got=%h exp=0000", op1); end
        press_key(7);
        checks++; if (op1 !== 16'h0007) begin errors++; $display("FAIL dec_digit got=%h exp=0007", op1); end
    endtask

    task automatic test_simultaneous();
        int py0;
        goto_key(5);
        do_press(B_C | B_R);
        checks++; if (op1 !== 16'h0075 || pos_x !== 3'd5) begin
            errors++; $display("FAIL simul_c_r got=op1 %h x %0d exp=0075 5", op1, pos_x); end
        py0 = m_py;
        @(negedge clk); btn_u = 1'b1;
        repeat (100) @(negedge clk);
        btn_u = 1'b0;
        m_py = (m_py + 3) % 4;
        @(negedge clk);
        checks++; if (int'(pos_y) !== (py0 + 3) % 4) begin errors++; $display("FAIL held_u got=%0d exp=%0d", pos_y, (py0 + 3) % 4); end
    endtask

    task automatic test_random();
        int e0;
        logic [4:0] m;
        bit bad;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            result = 16'($urandom);
            case ($urandom_range(0, 5))
                0: m = 5'($urandom);
                1: m = B_U;
                2: m = B_D;
                3: m = B_L;
                4: m = B_R;
                default: m = B_C;
            endcase
            e0 = exe_cnt;
            do_press(m);
            bad = (int'(pos_x) != m_px) || (int'(pos_y) != m_py) || (int'(op) != m_op) ||
                  (op1 !== m_op1) || (op2 !== m_op2) || (input_screen !== m_screen());
            checks++; if (bad) begin errors++;
                $display("FAIL rand_%0d got=x%0d y%0d op%0d %h %h scr %h exp=x%0d y%0d op%0d %h %h scr %h",
                         i, pos_x, pos_y, op, op1, op2, input_screen, m_px, m_py, m_op, m_op1, m_op2, m_screen()); end
            checks++; if (exe_cnt - e0 !== int'(m_exe)) begin errors++;
                $display("FAIL rand_exe_%0d got=%0d exp=%0d", i, exe_cnt - e0, m_exe); end
        end
    endtask

    task automatic test_async_reset();
        int e0;
        press_key(22);
        mode = 1'b1;
        press_key(1); press_key(16); press_key(2);
        goto_key(23);
        @(negedge clk);
        btn_c = 1'b1;
        e0 = exe_cnt;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        btn_c = 1'b0;
        btn_r = 1'b1;
        #1;
        checks++; if (exe !== 1'b0 || op1 !== 16'h0 || op2 !== 16'h0 || op !== 3'd0) begin
            errors++; $display("FAIL async_rst got=exe %b %h %h %0d exp=0 0000 0000 0", exe, op1, op2, op); end
        checks++; if (pos_x !== 3'd0 || pos_y !== 2'd0 || input_screen !== 16'h0) begin
            errors++; $display("FAIL async_rst_pos got=(%0d,%0d) %h exp=(0,0) 0000", pos_x, pos_y, input_screen); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        checks++; if (exe_cnt !== e0) begin errors++; $display("FAIL async_no_exe got=%0d exp=0", exe_cnt - e0); end
        checks++; if (pos_x !== 3'd0) begin errors++; $display("FAIL held_thru_reset got=%0d exp=0", pos_x); end
        btn_r = 1'b0;
        @(negedge clk);
        do_press(B_R);
        checks++; if (pos_x !== 3'd1) begin errors++; $display("FAIL after_reset_r got=%0d exp=1", pos_x); end
    endtask

    initial begin
        {btn_c, btn_u, btn_d, btn_l, btn_r} = 5'b0;
        mode = 1'b1;
        result = 16'h0;
        rst_n = 1'b1;
        test_reset();
        test_cursor_wrap();
        test_hex_entry();
        test_chaining();
        test_decimal();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calculator_keypad_ctrl.md
# calculator_keypad_ctrl

Cursor-and-entry controller for the VGA calculator. It sits directly upstream of `calculator_screen`: debounced push-buttons move a cursor over the 6x4 on-screen key grid and press the selected key. The block drives the `pos_x`, `pos_y`, `op`, `op1`, `op2` and `input_screen` inputs of `calculator_screen`. It also pulses an execute request to the ALU and accepts the ALU result for display and chaining.

## Interface
Parameters:
- `MAX_DIGITS`, default 4: nibbles accepted per operand.

Ports:
- `clk`  in  1  system clock (same domain as `calculator_screen`'s `clk_vga`).
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_u`, `btn_d`, `btn_l`, `btn_r`, `btn_c`  in  1 each  debounced, synchronized button levels.
- `mode`  in  1  0 = decimal (BCD entry), 1 = hexadecimal.
- `result`  in  16  ALU result, combinational from `op1`/`op2`/`op`.
- `pos_x`  out  3  cursor column, 0..5.
- `pos_y`  out  2  cursor row, 0..3.
- `op`  out  3  selected operation code.
- `op1`, `op2`  out  16  operands, nibble-packed.
- `input_screen`  out  16  value shown on the entry display.
- `exe`  out  1  one-cycle execute strobe.

## Operation
- **Edge detection.** Each button is rising-edge detected against a registered previous level. Only edges act.
- **Same-cycle edges.** At most one action is taken per cycle, by priority C > U > D > L > R. Lower-priority edges in that cycle are discarded.
- **Cursor movement.**
  - U/D: `pos_y` ∓1, wrapping 0↔3.
  - L/R: `pos_x` ∓1, wrapping 0↔5.
- **Key index.** k = `pos_y`*6 + `pos_x`.
  - k 0..15: hex digit k.
  - k 16..20: operations `+ - * & |`, with op codes 0..4.
  - k 21: CE (clear entry).
  - k 22: CLR (clear all).
  - k 23: EXE.
- **Digit validity.** When `mode`=0, digit keys ≥ 10 are ignored.
- **Digit entry.** A digit shifts in as value = {value[11:0], d}.
  - Accepted only while the digit count < `MAX_DIGITS`; further digits are ignored.
  - Changing `mode` never alters stored values.
- **States:** ENTER_OP1, ENTER_OP2, SHOW_RESULT.
  - **ENTER_OP1:**
    - Digit: shifts into `op1`.
    - Op key: sets `op`, clears `op2` and the count, moves to ENTER_OP2.
    - CE: clears `op1` and the count.
    - EXE: ignored.
  - **ENTER_OP2:**
    - Digit: shifts into `op2`.
    - Op key: overwrites `op`.
    - CE: clears `op2` and the count.
    - EXE: asserts `exe`, moves to SHOW_RESULT.
  - **SHOW_RESULT:**
    - Digit: `op1`=d, `op2`=0, count=1, moves to ENTER_OP1.
    - Op key: `op1`=`result`, sets `op`, `op2`=0, count=0, moves to ENTER_OP2 (chaining).
    - EXE: re-asserts `exe`.
    - CE: same as CLR.
  - **CLR, in any state:** `op1`=`op2`=0, `op`=0, count=0, moves to ENTER_OP1. The cursor is unchanged.
- **`input_screen`:** `op1` in ENTER_OP1, `op2` in ENTER_OP2, `result` in SHOW_RESULT.

## Timing
- **Reset values:** state ENTER_OP1, `pos_x`=0, `pos_y`=0, `op`=0, `op1`=`op2`=0, `exe`=0, count=0, edge registers=0. `input_screen` is therefore 0.
- **Button held through reset release:** produces no edge.
- **Latency:** a level rising at edge n (previous register 0) is acted on at edge n; registered outputs update after edge n, i.e. one cycle.
- **Held buttons:** a button held high causes exactly one action.
- **`exe`:** high for exactly one cycle per accepted EXE press.
- **`input_screen` in SHOW_RESULT:** combinational from `result`; all other outputs are registered.
- **Reset mid-operation:** asserting `rst_n` low clears everything immediately, asynchronously, including a pending `exe`.

## Structure
- **Package `calc_pkg`:**
  - `GRID_COLS`=6, `GRID_ROWS`=4.
  - Op-code localparams `OP_ADD`..`OP_OR`.
  - Key-index constants `KEY_CE`=21, `KEY_CLR`=22, `KEY_EXE`=23.
  - State enum `calc_state_t`.
  - These constants are shared with `calculator_screen` and the ALU.
- **Sub-module `btn_edge_detect`:** parameterized width, async active-low reset, one-cycle rising-edge pulses. Instantiated 5-wide.

## Test plan
- **Cursor wrap:** from reset, press L once → (`pos_x`,`pos_y`)=(5,0); press U once → (5,3); press R → (0,3).
- **Hex entry and execute:** `mode`=1, key sequence 1,2,A,B,C (five digits) → `op1`=16'h12AB, fifth digit ignored. Then `+`, 3, EXE → `op`=0, `op2`=16'h0003, `exe` high exactly 1 cycle.
- **Decimal gating:** `mode`=0, press key A (k=10) → `op1` unchanged. Press 7 → `op1`=16'h0007.
- **Chaining:** in SHOW_RESULT with `result`=16'h0042, press `*` → `op1`=16'h0042, `op`=2, `op2`=0, state ENTER_OP2.
- **Simultaneous edges:** C and R rise in the same cycle with the cursor on digit 5 → digit 5 entered, `pos_x` unchanged. U held for 100 cycles → single move.
- **Async reset mid-entry:** pulse `rst_n` low between clock edges during ENTER_OP2 → all outputs 0 immediately, no `exe`. A button held through reset release → no action.
